multi_phase_pwm: RTL and testbench
==================================

Name: multi_phase_pwm

Overview:
- N-channel PWM generator with a common timebase and parameterised counter width.
- Each channel drives a complementary high/low output pair with per-channel dead-time insertion.
- Two counter modes: edge-aligned (up counter) and true center-aligned (up/down counter).
- Period, duty and dead-time are double-buffered and transfer only at period boundaries; a period interrupt and a sync pulse trigger software updates and ADC sampling.

Parameters:
- CH, 3, number of channels.
- W, 16, counter/period/duty width in bits.
- DT_W, 10, dead-time counter width in bits.

Ports:
- Clk  in  1  clock.
- Reset_n  in  1  reset; synchronous, active-low.
- Enable  in  1  run; 0 holds the timebase and forces all outputs low.
- Center_Mode  in  1  0 = edge-aligned, 1 = up/down center-aligned; sampled with the shadow set.
- Period  in  W  period value.
- Duty  in  CH*W  flat duty vector; channel k occupies bits [k*W +: W].
- DeadTime  in  DT_W  dead time in Clk cycles.
- DeadTime_En  in  1  1 = complementary outputs with dead time; 0 = high side only, Pwm_L held 0.
- Load  in  1  one-cycle strobe; captures Period/Duty/DeadTime/Center_Mode into the shadow set.
- Int_En  in  1  interrupt enable.
- Int_Clear  in  1  clears Int_Active.
- Pwm_H  out  CH  high-side outputs.
- Pwm_L  out  CH  low-side outputs.
- Count  out  W  current timebase value.
- Dir  out  1  1 = counting down; always 0 in edge mode.
- Sync_Out  out  1  one-cycle pulse on the last cycle of each period.
- Int_Active  out  1  sticky period interrupt.

Behaviour:
- Reset: Count=0, Dir=0, Pwm_H=0, Pwm_L=0, Sync_Out=0, Int_Active=0.
  - Shadow and active sets cleared to 0; pending flag cleared.
  - Reset mid-operation aborts the period immediately.
- Period=0 is treated as 1 when transferred to the active set.
- Duty>Period is clamped to Period at transfer.
- Edge mode:
  - Count runs 0,1..P-1,0; period = P cycles.
  - Boundary = cycle with Count==P-1.
  - raw_k = (Count < D_k).
- Center mode:
  - Count runs 0,1..P-1,P-1..1,0, then repeats; period = 2P cycles.
  - Dir goes 1 on the cycle Count repeats P-1, and 0 on the cycle Count repeats 0.
  - Boundary = cycle with Count==0 and Dir==1.
  - raw_k = (Count >= P-D_k): 2*D_k high cycles, centered on the peak.
- D=0 gives raw constantly 0; D=P gives raw constantly 1.
- Double-buffering:
  - Load captures inputs into the shadow set and sets pending.
  - At a boundary with pending=1, the active set is copied from the shadow set and pending clears.
  - Load on a boundary cycle: the previous pending contents transfer now; the new values are shadowed with pending=1 and transfer at the next boundary.
  - Mode changes via transfer; Count restarts at 0, Dir=0.
  - While Enable=0, shadow transfers to active every cycle (immediate).
- Output timing: Pwm_H/Pwm_L are registered, 1 cycle after the Count value that changes raw.
- Dead time (DeadTime_En=1), per channel:
  - Any raw change forces both outputs low and loads dt_cnt_k=DeadTime.
  - dt_cnt_k decrements each cycle; when it reaches 0, Pwm_H=raw and Pwm_L=~raw.
  - Deasserting edges are undelayed; asserting edges are delayed DeadTime cycles.
  - A raw change during countdown reloads dt_cnt_k, so pulses shorter than DeadTime are swallowed.
  - DeadTime=0 gives plain complementary outputs.
  - Pwm_H & Pwm_L is never 1 for any channel in any cycle.
- DeadTime_En=0: Pwm_H=raw, Pwm_L=0, dt_cnt cleared.
- Enable=0:
  - Count=0, Dir=0, outputs 0, dt counters cleared, Sync_Out=0.
  - The first counting cycle after Enable rises shows Count=0.
- Sync_Out=1 exactly on boundary cycles.
- Interrupt:
  - At a boundary, Int_Active<=1 if Int_En=1.
  - Int_Clear clears Int_Active.
  - Boundary set wins over a simultaneous clear.
  - Int_En=0 does not clear an already active flag.
- Arithmetic: all compares unsigned W-bit; P-D is computed after clamping, so no underflow.

Test Plan:
- Edge: P=10, D0=3, D1=0, D2=10, DT off.
  - Pwm_H0 high 3 of every 10 cycles.
  - Pwm_H1 constant 0, Pwm_H2 constant 1.
  - Sync_Out every 10 cycles at Count=9.
- Center: P=8, D0=2.
  - Count 0..7,7..0.
  - Pwm_H0 high 4 cycles, spanning Count 6,7,7,6.
  - Period 16 cycles; Dir toggles at both turnarounds.
- Dead time: edge, P=20, D0=10, DT=3, DeadTime_En=1.
  - Pwm_H0 high 7 cycles, Pwm_L0 high 7 cycles, 3-cycle both-low gaps twice per period.
  - D0=2 gives Pwm_H0 never high.
  - Assert H&L never both 1.
- Shadow: Load P=12, D0=6 mid-period of P=10.
  - Old values hold until Count==9; the new period starts next cycle.
  - Load on a boundary cycle applies one period later.
- Clamp/interrupt: D0=50, P=10 gives 100% duty.
  - Int_En=1 with Int_Clear asserted on the boundary cycle: Int_Active=1.
  - Int_Clear the cycle after: Int_Active=0.
- Reset mid-period: Reset_n low at Count=5.
  - Next cycle all outputs 0, Count=0, pending cleared.

Source files
------------

// File: rtl/multi_phase_pwm.sv
// Multi-channel PWM generator: shared edge/center-aligned timebase,
// double-buffered period/duty/dead-time, complementary outputs with dead time.
module multi_phase_pwm #(
    parameter int CH   = 3,
    parameter int W    = 16,
    parameter int DT_W = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Enable,
    input  logic              Center_Mode,
    input  logic [W-1:0]      Period,
    input  logic [CH*W-1:0]   Duty,
    input  logic [DT_W-1:0]   DeadTime,
    input  logic              DeadTime_En,
    input  logic              Load,
    input  logic              Int_En,
    input  logic              Int_Clear,
    output logic [CH-1:0]     Pwm_H,
    output logic [CH-1:0]     Pwm_L,
    output logic [W-1:0]      Count,
    output logic              Dir,
    output logic              Sync_Out,
    output logic              Int_Active
);

    logic [W-1:0]    sh_period;
    logic [W-1:0]    sh_duty [CH];
    logic [DT_W-1:0] sh_dt;
    logic            sh_center;
    logic            pending;

    logic [W-1:0]    act_period;
    logic [W-1:0]    act_duty [CH];
    logic [DT_W-1:0] act_dt;
    logic            act_center;

    logic [W-1:0]    p_clamp;
    logic [W-1:0]    d_clamp [CH];
    logic [W-1:0]    last;
    logic            idle;
    logic            at_end;
    logic            boundary;
    logic            xfer;

    logic [CH-1:0]   raw;
    logic [CH-1:0]   raw_prev;
    logic [DT_W-1:0] dt_cnt [CH];

    // Shadow values as they will land in the active set (P>=1, D<=P)
    always_comb begin
        p_clamp = (sh_period == '0) ? W'(1) : sh_period;
        for (int k = 0; k < CH; k++) begin
            d_clamp[k] = (sh_duty[k] > p_clamp) ? p_clamp : sh_duty[k];
        end
    end

    // Period boundary detection and active-set transfer qualification;
    // an all-zero active period (only after reset) means not yet configured
    always_comb begin
        idle     = (act_period == '0);
        last     = act_period - W'(1);
        at_end   = act_center ? ((Count == '0) && Dir) : (Count == last);
        boundary = Enable && !idle && at_end;
        xfer     = !Enable || ((boundary || idle) && pending);
    end

    assign Sync_Out = boundary;

    // Shadow capture on Load, shadow-to-active copy on transfer
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sh_period  <= '0;
            sh_dt      <= '0;
            sh_center  <= 1'b0;
            pending    <= 1'b0;
            act_period <= '0;
            act_dt     <= '0;
            act_center <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                sh_duty[k]  <= '0;
                act_duty[k] <= '0;
            end
        end else begin
            if (xfer) begin
                act_period <= p_clamp;
                act_dt     <= sh_dt;
                act_center <= sh_center;
                pending    <= 1'b0;
                for (int k = 0; k < CH; k++) begin
                    act_duty[k] <= d_clamp[k];
                end
            end
            if (Load) begin
                sh_period <= Period;
                sh_dt     <= DeadTime;
                sh_center <= Center_Mode;
                pending   <= 1'b1;
                for (int k = 0; k < CH; k++) begin
                    sh_duty[k] <= Duty[k*W +: W];
                end
            end
        end
    end

    // Timebase: up counter, or up/down with each turnaround value held twice
    always_ff @(posedge Clk) begin
        if (!Reset_n || !Enable) begin
            Count <= '0;
            Dir   <= 1'b0;
        end else if (xfer || idle) begin
            Count <= '0;
            Dir   <= 1'b0;
        end else if (act_center) begin
            if (!Dir) begin
                if (Count == last) begin
                    Dir <= 1'b1;
                end else begin
                    Count <= Count + W'(1);
                end
            end else begin
                if (Count == '0) begin
                    Dir <= 1'b0;
                end else begin
                    Count <= Count - W'(1);
                end
            end
        end else begin
            Count <= (Count == last) ? '0 : Count + W'(1);
        end
    end

    // Raw compare per channel against the active duty
    always_comb begin
        raw = '0;
        for (int k = 0; k < CH; k++) begin
            if (!idle) begin
                if (act_center) begin
                    raw[k] = (Count >= (act_period - act_duty[k]));
                end else begin
                    raw[k] = (Count < act_duty[k]);
                end
            end
        end
    end

    // Output stage: any raw edge blanks both sides for DeadTime cycles
    always_ff @(posedge Clk) begin
        if (!Reset_n || !Enable) begin
            Pwm_H    <= '0;
            Pwm_L    <= '0;
            raw_prev <= '0;
            for (int k = 0; k < CH; k++) begin
                dt_cnt[k] <= '0;
            end
        end else begin
            raw_prev <= raw;
            for (int k = 0; k < CH; k++) begin
                if (!DeadTime_En) begin
                    Pwm_H[k]  <= raw[k];
                    Pwm_L[k]  <= 1'b0;
                    dt_cnt[k] <= '0;
                end else if (raw[k] != raw_prev[k]) begin
                    if (act_dt == '0) begin
                        Pwm_H[k]  <= raw[k];
                        Pwm_L[k]  <= !raw[k];
                        dt_cnt[k] <= '0;
                    end else begin
                        Pwm_H[k]  <= 1'b0;
                        Pwm_L[k]  <= 1'b0;
                        dt_cnt[k] <= act_dt;
                    end
                end else if (dt_cnt[k] > DT_W'(1)) begin
                    Pwm_H[k]  <= 1'b0;
                    Pwm_L[k]  <= 1'b0;
                    dt_cnt[k] <= dt_cnt[k] - DT_W'(1);
                end else begin
                    Pwm_H[k]  <= raw[k];
                    Pwm_L[k]  <= !raw[k];
                    dt_cnt[k] <= '0;
                end
            end
        end
    end

    // Sticky period interrupt; a boundary set beats a same-cycle clear
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Int_Active <= 1'b0;
        end else if (boundary && Int_En) begin
            Int_Active <= 1'b1;
        end else if (Int_Clear) begin
            Int_Active <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_phase_pwm.sv
// Testbench for multi_phase_pwm: directed scenarios plus randomized
// traffic checked against a phase-based behavioural model.
module tb_multi_phase_pwm;

    localparam int CH   = 3;
    localparam int W    = 16;
    localparam int DT_W = 10;
    localparam int BIG  = 1 << 20;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              Enable;
    logic              Center_Mode;
    logic [W-1:0]      Period;
    logic [CH*W-1:0]   Duty;
    logic [DT_W-1:0]   DeadTime;
    logic              DeadTime_En;
    logic              Load;
    logic              Int_En;
    logic              Int_Clear;
    logic [CH-1:0]     Pwm_H;
    logic [CH-1:0]     Pwm_L;
    logic [W-1:0]      Count;
    logic              Dir;
    logic              Sync_Out;
    logic              Int_Active;

    int checks = 0;
    int errors = 0;

    multi_phase_pwm #(.CH(CH), .W(W), .DT_W(DT_W)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Enable      (Enable),
        .Center_Mode (Center_Mode),
        .Period      (Period),
        .Duty        (Duty),
        .DeadTime    (DeadTime),
        .DeadTime_En (DeadTime_En),
        .Load        (Load),
        .Int_En      (Int_En),
        .Int_Clear   (Int_Clear),
        .Pwm_H       (Pwm_H),
        .Pwm_L       (Pwm_L),
        .Count       (Count),
        .Dir         (Dir),
        .Sync_Out    (Sync_Out),
        .Int_Active  (Int_Active)
    );

    always #5 Clk = ~Clk;

    // Reference model: position within the period plus run lengths of raw
    int m_p, m_dt, m_t, s_p, s_dt;
    int m_d [CH];
    int s_d [CH];
    bit m_c, s_c, s_pend, m_int;
    bit m_h [CH];
    bit m_l [CH];
    bit run_val [CH];
    int run_len [CH];

    function automatic int m_len();
        return m_c ? 2 * m_p : m_p;
    endfunction

    function automatic int m_count();
        if (m_p == 0) return 0;
        if (!m_c) return m_t;
        return (m_t < m_p) ? m_t : 2 * m_p - 1 - m_t;
    endfunction

    function automatic bit m_dir();
        return (m_p != 0) && m_c && (m_t >= m_p);
    endfunction

    function automatic bit m_bound();
        return (m_p != 0) && (m_t == m_len() - 1);
    endfunction

    function automatic bit m_raw(int k);
        int c;
        if (m_p == 0) return 1'b0;
        c = m_count();
        return m_c ? (c >= m_p - m_d[k]) : (c < m_d[k]);
    endfunction

    task automatic model_step();
        bit bnd;
        bit xf;
        bit r [CH];
        int pc;
        if (!Reset_n) begin
            m_p = 0; m_dt = 0; m_c = 0; m_t = 0;
            s_p = 0; s_dt = 0; s_c = 0; s_pend = 0; m_int = 0;
            for (int k = 0; k < CH; k++) begin
                m_d[k] = 0; s_d[k] = 0; m_h[k] = 0; m_l[k] = 0;
                run_val[k] = 0; run_len[k] = BIG;
            end
            return;
        end
        bnd = Enable && m_bound();
        for (int k = 0; k < CH; k++) r[k] = m_raw(k);
        for (int k = 0; k < CH; k++) begin
            if (!Enable) begin
                m_h[k] = 0; m_l[k] = 0;
                run_val[k] = 0; run_len[k] = BIG;
            end else begin
                if (r[k] == run_val[k]) begin
                    if (run_len[k] < BIG) run_len[k]++;
                end else begin
                    run_val[k] = r[k]; run_len[k] = 1;
                end
                if (DeadTime_En) begin
                    m_h[k] = run_val[k] && (run_len[k] >= m_dt + 1);
                    m_l[k] = !run_val[k] && (run_len[k] >= m_dt + 1);
                end else begin
                    m_h[k] = r[k]; m_l[k] = 0;
                end
            end
        end
        if (bnd && Int_En) m_int = 1;
        else if (Int_Clear) m_int = 0;
        xf = !Enable || ((bnd || m_p == 0) && s_pend);
        if (xf) begin
            pc = (s_p == 0) ? 1 : s_p;
            m_p = pc; m_dt = s_dt; m_c = s_c; s_pend = 0; m_t = 0;
            for (int k = 0; k < CH; k++) m_d[k] = (s_d[k] > pc) ? pc : s_d[k];
        end else if (m_p == 0) begin
            m_t = 0;
        end else begin
            m_t = (m_t + 1) % m_len();
        end
        if (Load) begin
            s_p = int'(Period); s_dt = int'(DeadTime); s_c = Center_Mode; s_pend = 1;
            for (int k = 0; k < CH; k++) s_d[k] = int'(Duty[k*W +: W]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_cfg(int p, int d0, int d1, int d2, int dt, bit cen);
        Period      = W'(p);
        Duty[0*W +: W] = W'(d0);
        Duty[1*W +: W] = W'(d1);
        Duty[2*W +: W] = W'(d2);
        DeadTime    = DT_W'(dt);
        Center_Mode = cen;
    endtask

    task automatic configure(int p, int d0, int d1, int d2, int dt, bit cen, bit dten);
        Enable = 1'b0;
        DeadTime_En = dten;
        set_cfg(p, d0, d1, d2, dt, cen);
        Load = 1'b1;
        tick();
        Load = 1'b0;
        tick();
        Enable = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Enable = 1'b0; Load = 1'b0;
        Int_En = 1'b0; Int_Clear = 1'b0; DeadTime_En = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 1'b0);
        tick();
        tick();
        Reset_n = 1'b1;
        #1;
        checks++;
        if (Count !== '0 || Dir !== 1'b0) begin
            errors++;
            $display("FAIL reset_count got=%0d/%0b exp=0/0", Count, Dir);
        end
        checks++;
        if (Pwm_H !== '0 || Pwm_L !== '0) begin
            errors++;
            $display("FAIL reset_pwm got=%b/%b exp=000/000", Pwm_H, Pwm_L);
        end
        checks++;
        if (Sync_Out !== 1'b0 || Int_Active !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got=%0b/%0b exp=0/0", Sync_Out, Int_Active);
        end
    endtask

    task automatic test_edge();
        int hi;
        logic [CH-1:0] eh;
        configure(10, 3, 0, 10, 0, 1'b0, 1'b0);
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            eh = '0;
            if (i >= 1) begin
                eh[0] = (((i - 1) % 10) < 3);
                eh[2] = 1'b1;
            end
            if (i >= 1 && i <= 10 && Pwm_H[0]) hi++;
            checks++;
            if (Count !== W'(i % 10)) begin
                errors++;
                $display("FAIL edge_count i=%0d got=%0d exp=%0d", i, Count, i % 10);
            end
            checks++;
            if (Sync_Out !== ((i % 10) == 9)) begin
                errors++;
                $display("FAIL edge_sync i=%0d got=%0b exp=%0b", i, Sync_Out, (i % 10) == 9);
            end
            checks++;
            if (Pwm_H !== eh || Pwm_L !== '0) begin
                errors++;
                $display("FAIL edge_pwm i=%0d got=%b/%b exp=%b/000", i, Pwm_H, Pwm_L, eh);
            end
            tick();
        end
        checks++;
        if (hi !== 3) begin
            errors++;
            $display("FAIL edge_duty got=%0d exp=3", hi);
        end
    endtask

    task automatic test_center();
        int t, c, pc, hi;
        logic [CH-1:0] eh;
        configure(8, 2, 0, 8, 0, 1'b1, 1'b0);
        hi = 0;
        pc = 0;
        for (int i = 0; i < 34; i++) begin
            t = i % 16;
            c = (t < 8) ? t : 15 - t;
            eh = '0;
            if (i >= 1) begin
                eh[0] = (pc >= 6);
                eh[2] = 1'b1;
            end
            if (i >= 1 && i <= 16 && Pwm_H[0]) hi++;
            checks++;
            if (Count !== W'(c) || Dir !== (t >= 8)) begin
                errors++;
                $display("FAIL ctr_count i=%0d got=%0d/%0b exp=%0d/%0b", i, Count, Dir, c, t >= 8);
            end
            checks++;
            if (Sync_Out !== (t == 15)) begin
                errors++;
                $display("FAIL ctr_sync i=%0d got=%0b exp=%0b", i, Sync_Out, t == 15);
            end
            checks++;
            if (Pwm_H !== eh || Pwm_L !== '0) begin
                errors++;
                $display("FAIL ctr_pwm i=%0d got=%b/%b exp=%b/000", i, Pwm_H, Pwm_L, eh);
            end
            pc = c;
            tick();
        end
        checks++;
        if (hi !== 4) begin
            errors++;
            $display("FAIL ctr_duty got=%0d exp=4", hi);
        end
    endtask

    task automatic test_deadtime();
        int m;
        logic [CH-1:0] eh, el;
        configure(20, 10, 0, 0, 3, 1'b0, 1'b1);
        for (int i = 0; i < 45; i++) begin
            m = i % 20;
            eh = '0;
            el = '0;
            if (i >= 1) begin
                eh[0] = (m >= 4 && m <= 10);
                el[0] = (m >= 14 || m == 0);
                el[1] = 1'b1;
                el[2] = 1'b1;
            end
            checks++;
            if (Pwm_H !== eh || Pwm_L !== el) begin
                errors++;
                $display("FAIL dt_pwm i=%0d got=%b/%b exp=%b/%b", i, Pwm_H, Pwm_L, eh, el);
            end
            tick();
        end
        set_cfg(20, 2, 0, 0, 3, 1'b0);
        Load = 1'b1;
        tick();
        Load = 1'b0;
        for (int i = 0; i < 65; i++) begin
            if (i >= 25) begin
                checks++;
                if (Pwm_H[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL dt_swallow i=%0d got=%0b exp=0", i, Pwm_H[0]);
                end
            end
            checks++;
            if ((Pwm_H & Pwm_L) !== '0) begin
                errors++;
                $display("FAIL dt_overlap i=%0d got=%b/%b exp=disjoint", i, Pwm_H, Pwm_L);
            end
            tick();
        end
    endtask

    task automatic test_shadow();
        int e;
        configure(10, 3, 0, 0, 0, 1'b0, 1'b0);
        repeat (4) tick();
        set_cfg(12, 6, 0, 0, 0, 1'b0);
        Load = 1'b1;
        tick();
        Load = 1'b0;
        for (int j = 0; j < 17; j++) begin
            e = (j < 5) ? 5 + j : j - 5;
            checks++;
            if (Count !== W'(e)) begin
                errors++;
                $display("FAIL shadow_count j=%0d got=%0d exp=%0d", j, Count, e);
            end
            checks++;
            if (Sync_Out !== (e == ((j < 5) ? 9 : 11))) begin
                errors++;
                $display("FAIL shadow_sync j=%0d got=%0b exp=%0b", j, Sync_Out, e == ((j < 5) ? 9 : 11));
            end
            tick();
        end
        repeat (3) tick();
        set_cfg(7, 3, 0, 0, 0, 1'b0);
        Load = 1'b1;
        tick();
        Load = 1'b0;
        repeat (7) tick();
        checks++;
        if (Count !== W'(11) || Sync_Out !== 1'b1) begin
            errors++;
            $display("FAIL shadow_bnd got=%0d/%0b exp=11/1", Count, Sync_Out);
        end
        set_cfg(5, 3, 0, 0, 0, 1'b0);
        Load = 1'b1;
        tick();
        Load = 1'b0;
        for (int j = 0; j < 17; j++) begin
            e = (j < 7) ? j : (j - 7) % 5;
            checks++;
            if (Count !== W'(e)) begin
                errors++;
                $display("FAIL shadow_late j=%0d got=%0d exp=%0d", j, Count, e);
            end
            tick();
        end
    endtask

    task automatic test_clamp_int();
        Int_En = 1'b1;
        Int_Clear = 1'b0;
        configure(10, 50, 0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (Pwm_H[0] !== (i >= 1)) begin
                errors++;
                $display("FAIL clamp_pwm i=%0d got=%0b exp=%0b", i, Pwm_H[0], i >= 1);
            end
            tick();
        end
        repeat (9) tick();
        checks++;
        if (Sync_Out !== 1'b1) begin
            errors++;
            $display("FAIL int_bnd got=%0b exp=1", Sync_Out);
        end
        Int_Clear = 1'b1;
        tick();
        checks++;
        if (Int_Active !== 1'b1) begin
            errors++;
            $display("FAIL int_set_wins got=%0b exp=1", Int_Active);
        end
        tick();
        checks++;
        if (Int_Active !== 1'b0) begin
            errors++;
            $display("FAIL int_clear got=%0b exp=0", Int_Active);
        end
        Int_Clear = 1'b0;
        Int_En = 1'b0;
        repeat (12) tick();
        checks++;
        if (Int_Active !== 1'b0) begin
            errors++;
            $display("FAIL int_disabled got=%0b exp=0", Int_Active);
        end
        Int_En = 1'b1;
        repeat (7) tick();
        checks++;
        if (Int_Active !== 1'b1) begin
            errors++;
            $display("FAIL int_enabled got=%0b exp=1", Int_Active);
        end
        Int_En = 1'b0;
        repeat (3) tick();
        checks++;
        if (Int_Active !== 1'b1) begin
            errors++;
            $display("FAIL int_sticky got=%0b exp=1", Int_Active);
        end
    endtask

    task automatic test_reset_mid();
        configure(10, 3, 0, 0, 0, 1'b0, 1'b0);
        repeat (2) tick();
        set_cfg(4, 3, 0, 0, 0, 1'b0);
        Load = 1'b1;
        tick();
        Load = 1'b0;
        repeat (2) tick();
        checks++;
        if (Count !== W'(5)) begin
            errors++;
            $display("FAIL rmid_pre got=%0d exp=5", Count);
        end
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        #1;
        checks++;
        if (Count !== '0 || Dir !== 1'b0 || Pwm_H !== '0 || Pwm_L !== '0
            || Sync_Out !== 1'b0 || Int_Active !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state got=%0d/%0b/%b/%b/%0b/%0b exp=0/0/000/000/0/0",
                     Count, Dir, Pwm_H, Pwm_L, Sync_Out, Int_Active);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (Count !== '0 || Sync_Out !== 1'b0 || Pwm_H !== '0) begin
                errors++;
                $display("FAIL rmid_idle i=%0d got=%0d/%0b/%b exp=0/0/000", i, Count, Sync_Out, Pwm_H);
            end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] eh, el;
        Reset_n = 1'b0;
        Load = 1'b0;
        Int_Clear = 1'b0;
        tick();
        Reset_n = 1'b1;
        for (int r = 0; r < 10; r++) begin
            Enable = 1'b0;
            DeadTime_En = 1'($urandom_range(0, 1));
            Int_En = 1'($urandom_range(0, 1));
            set_cfg($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 14),
                    $urandom_range(0, 14), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
            Load = 1'b1;
            tick();
            Load = 1'b0;
            tick();
            for (int c = 0; c < 150; c++) begin
                Enable = ($urandom_range(0, 59) != 0);
                Int_Clear = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 29) == 0) Int_En = !Int_En;
                Load = ($urandom_range(0, 19) == 0);
                if (Load) begin
                    Period = W'($urandom_range(0, 12));
                    for (int k = 0; k < CH; k++) Duty[k*W +: W] = W'($urandom_range(0, 14));
                    Center_Mode = 1'($urandom_range(0, 1));
                end
                #1;
                for (int k = 0; k < CH; k++) begin
                    eh[k] = m_h[k];
                    el[k] = m_l[k];
                end
                checks++;
                if (Count !== W'(m_count()) || Dir !== m_dir()) begin
                    errors++;
                    $display("FAIL rnd_count r=%0d c=%0d got=%0d/%0b exp=%0d/%0b", r, c, Count, Dir, m_count(), m_dir());
                end
                checks++;
                if (Sync_Out !== (Enable && m_bound())) begin
                    errors++;
                    $display("FAIL rnd_sync r=%0d c=%0d got=%0b exp=%0b", r, c, Sync_Out, Enable && m_bound());
                end
                checks++;
                if (Pwm_H !== eh || Pwm_L !== el) begin
                    errors++;
                    $display("FAIL rnd_pwm r=%0d c=%0d got=%b/%b exp=%b/%b", r, c, Pwm_H, Pwm_L, eh, el);
                end
                checks++;
                if (Int_Active !== m_int) begin
                    errors++;
                    $display("FAIL rnd_int r=%0d c=%0d got=%0b exp=%0b", r, c, Int_Active, m_int);
                end
                checks++;
                if ((Pwm_H & Pwm_L) !== '0) begin
                    errors++;
                    $display("FAIL rnd_overlap r=%0d c=%0d got=%b/%b exp=disjoint", r, c, Pwm_H, Pwm_L);
                end
                tick();
            end
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        Enable = 1'b0;
        Load = 1'b0;
        Int_En = 1'b0;
        Int_Clear = 1'b0;
        DeadTime_En = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 1'b0);
        #1;
        test_reset();
        test_edge();
        test_center();
        test_deadtime();
        test_shadow();
        test_clamp_int();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
